// File: rtl/count_display_driver.sv
// count_display_driver: sequential double-dabble BCD conversion of Count driving a 4-digit multiplexed 7-segment display.
// Optional feature macro: LEADING_ZERO_BLANK_EN blanks leading zeros on the hundreds and tens digits.
module count_display_driver #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] Count,
  input  logic       Overflow,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      r_state;
  logic [7:0]  r_snap;
  logic [19:0] r_shreg;
  logic [3:0]  r_bitcnt;
  logic [11:0] r_bcd;
  logic        r_busy;
  logic        r_ovf;
  logic [15:0] r_pre;
  logic [1:0]  r_idx;
  logic        r_idx_chg;

  logic [19:0] w_adj;
  logic [3:0]  w_digit;
  logic        w_blank;
  logic [6:0]  w_pattern;
  logic        w_wrap;

  assign w_wrap = (r_pre == REFRESH_DIV - 16'd1);
  assign busy   = r_busy;

  // NOTE: combinational blocks use blocking '=' with a default first so no latch is inferred.
  always_comb begin
    w_adj = r_shreg;
    for (int n = 0; n < 3; n++) begin
      if (r_shreg[8+4*n +: 4] >= 4'd5)
        w_adj[8+4*n +: 4] = r_shreg[8+4*n +: 4] + 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_snap   <= '0;
      r_shreg  <= '0;
      r_bitcnt <= '0;
      r_bcd    <= '0;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (Count != r_snap) begin
            r_snap   <= Count;
            r_shreg  <= {12'b0, Count};
            r_bitcnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= SHIFT;
          end
        end
        SHIFT: begin
          r_shreg  <= {w_adj[18:0], 1'b0};
          r_bitcnt <= r_bitcnt + 4'd1;
          if (r_bitcnt == 4'd7) r_state <= DONE;
        end
        DONE: begin
          r_bcd   <= r_shreg[19:8];
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_digit = 4'd0;
    w_blank = 1'b0;
    case (r_idx)
      2'd0: w_digit = r_bcd[3:0];
      2'd1: begin
        w_digit = r_bcd[7:4];
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = (r_bcd[11:8] == 4'd0) && (r_bcd[7:4] == 4'd0);
`else
        w_blank = 1'b0;
`endif
      end
      2'd2: begin
        w_digit = r_bcd[11:8];
`ifdef LEADING_ZERO_BLANK_EN
        w_blank = (r_bcd[11:8] == 4'd0);
`else
        w_blank = 1'b0;
`endif
      end
      default: w_digit = 4'd0;
    endcase

    case (w_digit)
      4'd0:    w_pattern = 7'b1000000;
      4'd1:    w_pattern = 7'b1111001;
      4'd2:    w_pattern = 7'b0100100;
      4'd3:    w_pattern = 7'b0110000;
      4'd4:    w_pattern = 7'b0011001;
      4'd5:    w_pattern = 7'b0010010;
      4'd6:    w_pattern = 7'b0000010;
      4'd7:    w_pattern = 7'b1111000;
      4'd8:    w_pattern = 7'b0000000;
      4'd9:    w_pattern = 7'b0010000;
      default: w_pattern = 7'b1111111;
    endcase

    // Slot 3 is the overflow indicator rather than a decimal digit.
    if (r_idx == 2'd3)
      w_pattern = r_ovf ? 7'b0001110 : 7'b1111111;
    else if (w_blank)
      w_pattern = 7'b1111111;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ovf     <= 1'b0;
      r_pre     <= '0;
      r_idx     <= '0;
      r_idx_chg <= 1'b0;
      seg       <= 7'h7F;
      an        <= 4'hF;
      dp        <= 1'b1;
    end else begin
      r_ovf     <= Overflow;
      dp        <= 1'b1;
      r_idx_chg <= w_wrap;
      if (w_wrap) begin
        r_pre <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_pre <= r_pre + 16'd1;
      end
      // Outputs refresh once per slot, on the edge after the digit index moves.
      if (r_idx_chg) begin
        an  <= ~(4'b0001 << r_idx);
        seg <= w_pattern;
      end
    end
  end

endmodule

// File: tb/tb_count_display_driver.sv
// Self-checking bench for count_display_driver: decimal-arithmetic reference model, directed scenarios and random stimulus.
module tb_count_display_driver;

  localparam int DIV = 4;
  localparam logic [6:0] LUT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] Count = 8'd0;
  logic       Overflow = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  count_display_driver #(.REFRESH_DIV(16'(DIV))) dut (
    .clock    (clock),
    .reset    (reset),
    .Count    (Count),
    .Overflow (Overflow),
    .seg      (seg),
    .an       (an),
    .dp       (dp),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_pattern(input logic [1:0] idx, input int val, input bit ovf);
    int h, t, o;
    h = val / 100;
    t = (val / 10) % 10;
    o = val % 10;
    case (idx)
      2'd0: return LUT[o];
      2'd1: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (h == 0 && t == 0) return 7'h7F;
`endif
        return LUT[t];
      end
      2'd2: begin
`ifdef LEADING_ZERO_BLANK_EN
        if (h == 0) return 7'h7F;
`endif
        return LUT[h];
      end
      default: return ovf ? 7'b0001110 : 7'h7F;
    endcase
  endfunction

  // Reference model: a conversion is a 9-cycle busy window, after which the captured value is shown.
  logic [7:0] m_snap = 8'd0, m_pend = 8'd0, m_shown = 8'd0;
  int         m_cnt = 0;
  int         m_pre = 0;
  logic [1:0] m_idx = 2'd0;
  bit         m_chg = 1'b0;
  bit         m_ovf = 1'b0;
  logic [6:0] m_seg = 7'h7F;
  logic [3:0] m_an = 4'hF;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_snap <= 8'd0; m_pend <= 8'd0; m_shown <= 8'd0; m_cnt <= 0;
      m_pre <= 0; m_idx <= 2'd0; m_chg <= 1'b0; m_ovf <= 1'b0;
      m_seg <= 7'h7F; m_an <= 4'hF;
    end else begin
      if (m_chg) begin
        m_an  <= ~(4'b0001 << m_idx);
        m_seg <= exp_pattern(m_idx, int'(m_shown), m_ovf);
      end
      m_chg <= (m_pre == DIV - 1);
      if (m_pre == DIV - 1) begin
        m_pre <= 0;
        m_idx <= m_idx + 2'd1;
      end else begin
        m_pre <= m_pre + 1;
      end
      m_ovf <= Overflow;
      if (m_cnt == 0) begin
        if (Count != m_snap) begin
          m_snap <= Count;
          m_pend <= Count;
          m_cnt  <= 9;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) m_shown <= m_pend;
      end
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("seg", 32'(seg), 32'(m_seg));
      check("an", 32'(an), 32'(m_an));
      check("dp", 32'(dp), 32'd1);
      check("busy", 32'(busy), 32'(m_cnt != 0));
    end
  end

  logic [6:0] cap [4];

  task automatic settle_and_capture();
    repeat (12) @(negedge clock);
    for (int s = 0; s < 4; s++) cap[s] = 7'bx;
    repeat (20) begin
      @(negedge clock);
      case (an)
        4'hE: cap[0] = seg;
        4'hD: cap[1] = seg;
        4'hB: cap[2] = seg;
        4'h7: cap[3] = seg;
        default: ;
      endcase
    end
  endtask

  task automatic mid_cycle_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    check({tag, "_seg"}, 32'(seg), 32'h7F);
    check({tag, "_an"}, 32'(an), 32'hF);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic bs [11];

    #1 reset = 1'b1;
    repeat (2) @(negedge clock);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_an", 32'(an), 32'hF);
    check("reset_dp", 32'(dp), 32'd1);
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    cmp_en = 1'b1;

    // Reset asserted mid-frame while a conversion is running and the display is lit.
    Count = 8'd99;
    repeat (7) @(negedge clock);
    Count = 8'd173;
    mid_cycle_reset("midframe_rst");

    // 173: nine busy cycles, then 1/7/3 on the display.
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (busy) n++;
    end
    check("busy_cycles_173", n, 9);
    settle_and_capture();
    check("d173_ones", 32'(cap[0]), 32'b0110000);
    check("d173_tens", 32'(cap[1]), 32'b1111000);
    check("d173_hund", 32'(cap[2]), 32'b1111001);
    check("d173_ovf", 32'(cap[3]), 32'b1111111);

    // 255 with overflow flag, then flag dropped.
    Count = 8'd255;
    Overflow = 1'b1;
    settle_and_capture();
    check("d255_ones", 32'(cap[0]), 32'b0010010);
    check("d255_tens", 32'(cap[1]), 32'b0010010);
    check("d255_hund", 32'(cap[2]), 32'b0100100);
    check("d255_ovf_on", 32'(cap[3]), 32'b0001110);
    Overflow = 1'b0;
    settle_and_capture();
    check("d255_ovf_off", 32'(cap[3]), 32'b1111111);

    // 7: leading-zero handling depends on the build option.
    Count = 8'd7;
    settle_and_capture();
    check("d7_ones", 32'(cap[0]), 32'b1111000);
`ifdef LEADING_ZERO_BLANK_EN
    check("d7_tens", 32'(cap[1]), 32'b1111111);
    check("d7_hund", 32'(cap[2]), 32'b1111111);
`else
    check("d7_tens", 32'(cap[1]), 32'b1000000);
    check("d7_hund", 32'(cap[2]), 32'b1000000);
`endif

    // Count moves 40->41 mid-conversion: one idle cycle, then a second conversion.
    Count = 8'd40;
    for (int k = 0; k < 11; k++) begin
      @(negedge clock);
      bs[k] = busy;
      if (k == 2) Count = 8'd41;
    end
    check("snap_busy_last", 32'(bs[8]), 32'd1);
    check("snap_idle_gap", 32'(bs[9]), 32'd0);
    check("snap_restart", 32'(bs[10]), 32'd1);
    settle_and_capture();
    check("d41_ones", 32'(cap[0]), 32'b1111001);
    check("d41_tens", 32'(cap[1]), 32'b0011001);
`ifdef LEADING_ZERO_BLANK_EN
    check("d41_hund", 32'(cap[2]), 32'b1111111);
`else
    check("d41_hund", 32'(cap[2]), 32'b1000000);
`endif

    // Reset during SHIFT for 200, then reconversion with Count held.
    Count = 8'd200;
    repeat (3) @(negedge clock);
    check("shift_busy", 32'(busy), 32'd1);
    mid_cycle_reset("shift_rst");
    settle_and_capture();
    check("d200_ones", 32'(cap[0]), 32'b1000000);
    check("d200_tens", 32'(cap[1]), 32'b1000000);
    check("d200_hund", 32'(cap[2]), 32'b0100100);

    // Random traffic: jumps, counter-style increments, overflow toggles, occasional resets.
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      case ($urandom_range(0, 3))
        0: Count = 8'($urandom);
        1: Count = Count + 8'd1;
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) Overflow = ~Overflow;
      if ($urandom_range(0, 99) == 0) begin
        #2 reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
    end
    repeat (40) @(negedge clock);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
